// File: rtl/alu_exec_if.sv
// alu_exec_if: controller-to-ALU command and result bundle
interface alu_exec_if;
  logic        alu_en;
  logic [7:0]  alu_op;
  logic [1:0]  op2_dir;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] instr;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        illegal_op;
  modport master (
    output alu_en, alu_op, op2_dir, rs1_data, rs2_data, instr,
    input  result, zero, busy, done, illegal_op
  );
  modport slave (
    input  alu_en, alu_op, op2_dir, rs1_data, rs2_data, instr,
    output result, zero, busy, done, illegal_op
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: single-cycle ALU plus iterative shift-add MUL and restoring signed DIV
module alu_exec #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  alu
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX} state_t;
  state_t r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a, r_b, r_acc, r_quo, r_div, r_result;
  logic [XLEN:0]   r_rem;
  logic            r_neg, r_zero, r_done, r_ill;
  logic [XLEN-1:0] w_op2, w_alu, w_acc_n, w_a_n, w_b_n, w_quo_n, w_q;
  logic [XLEN:0]   w_rem_n;
  logic            w_mul, w_div, w_div_sp, w_last;
  assign w_op2 = alu.op2_dir == 2'b00 ? alu.rs2_data :
                 alu.op2_dir == 2'b10 ? {{20{alu.instr[31]}}, alu.instr[31:20]} : '0;
  assign w_mul    = alu.alu_op == 8'd3;
  assign w_div    = alu.alu_op == 8'd4;
  assign w_div_sp = w_op2 == '0 || (alu.rs1_data == 32'h8000_0000 && w_op2 == 32'hFFFF_FFFF);
  assign w_last   = r_cnt == CW'(N - 1);
  assign w_q      = r_neg ? -r_quo : r_quo;
  always_comb begin
    w_alu = '0;
    case (alu.alu_op)
      8'd0, 8'd1: w_alu = alu.rs1_data + w_op2;
      8'd2:       w_alu = alu.rs1_data - w_op2;
      8'd4:       w_alu = w_op2 == '0 ? 32'hFFFF_FFFF : 32'h8000_0000;
      8'd5:       w_alu = alu.rs1_data << w_op2[4:0];
      8'd6:       w_alu = alu.rs1_data >> w_op2[4:0];
      8'd7:       w_alu = alu.rs1_data & w_op2;
      8'd8:       w_alu = alu.rs1_data | w_op2;
      8'd9:       w_alu = ~alu.rs1_data;
      8'd10:      w_alu = alu.rs1_data ^ w_op2;
      8'd11:      w_alu = {alu.instr[31:12], 12'b0};
      default:    w_alu = '0;
    endcase
  end
  always_comb begin
    w_acc_n = r_acc;
    for (int k = 0; k < BITS_PER_CYCLE; k++)
      if (r_b[k]) w_acc_n = w_acc_n + (r_a << k);
    w_a_n = r_a << BITS_PER_CYCLE;
    w_b_n = r_b >> BITS_PER_CYCLE;
  end
  // restoring divide: dividend bits shift from r_quo into the remainder, quotient bits fill in behind
  always_comb begin
    w_rem_n = r_rem;
    w_quo_n = r_quo;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      w_rem_n = {w_rem_n[XLEN-1:0], w_quo_n[XLEN-1]};
      w_quo_n = {w_quo_n[XLEN-2:0], 1'b0};
      if (w_rem_n >= {1'b0, r_div}) begin
        w_rem_n    = w_rem_n - {1'b0, r_div};
        w_quo_n[0] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !alu.alu_en ? IDLE : w_mul ? MUL_RUN : (w_div && !w_div_sp) ? DIV_RUN : IDLE;
      MUL_RUN: w_next = w_last ? IDLE : MUL_RUN;
      DIV_RUN: w_next = w_last ? DIV_FIX : DIV_RUN;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    alu.busy       = r_state != IDLE;
    alu.result     = r_result;
    alu.zero       = r_zero;
    alu.done       = r_done;
    alu.illegal_op = r_ill;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ill  <= 1'b0;
      case (r_state)
        IDLE: if (alu.alu_en) begin
          r_cnt <= '0;
          if (w_mul) begin
            r_a   <= alu.rs1_data;
            r_b   <= w_op2;
            r_acc <= '0;
          end else if (w_div && !w_div_sp) begin
            r_neg <= alu.rs1_data[XLEN-1] ^ w_op2[XLEN-1];
            r_quo <= alu.rs1_data[XLEN-1] ? -alu.rs1_data : alu.rs1_data;
            r_div <= w_op2[XLEN-1] ? -w_op2 : w_op2;
            r_rem <= '0;
          end else begin
            r_result <= w_alu;
            r_zero   <= w_alu == '0;
            r_done   <= 1'b1;
            r_ill    <= alu.alu_op > 8'd11;
          end
        end
        MUL_RUN: begin
          r_a   <= w_a_n;
          r_b   <= w_b_n;
          r_acc <= w_acc_n;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_acc_n;
            r_zero   <= w_acc_n == '0;
            r_done   <= 1'b1;
          end
        end
        DIV_RUN: begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          r_result <= w_q;
          r_zero   <= w_q == '0;
          r_done   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit that responds to the controller's ALU command interface (alu_en, alu_op, op2_dir).
- Performs single-cycle logic and arithmetic, plus iterative multi-cycle MUL/DIV.
- Exposes a busy/done handshake so the controller holds its write-back state until the result is valid.
- Sits between the register file read ports, IR and the register file write-back mux (reg_in_dir=0 path).

Parameters:
XLEN, 32, datapath width; only 32 is supported because immediate extraction is fixed to the RV32 format.
BITS_PER_CYCLE, 1, MUL/DIV bits retired per iteration; legal values 1, 2, 4; iteration count N = 32/BITS_PER_CYCLE.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_en  in  1  command strobe; sampled only in IDLE
alu_op  in  8  operation code: ADD=0, ADDI=1, SUB=2, MUL=3, DIV=4, SLL=5, SRL=6, AND=7, OR=8, NOT=9, XOR=10, LUI=11
op2_dir  in  2  op2 source: 00=rs2_data, 10=I-immediate, 01/11=zero
rs1_data  in  32  operand 1
rs2_data  in  32  operand 2 candidate
instr  in  32  current IR contents; I-imm=sext(instr[31:20]), U-imm=instr[31:12]
result  out  32  registered result, held until next accepted command
zero  out  1  registered (result==0), updated together with result
busy  out  1  high from the cycle after acceptance until done, MUL/DIV only
done  out  1  one-cycle pulse when result is updated
illegal_op  out  1  one-cycle pulse, coincident with done, for alu_op>11

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result=0, zero=1, busy=0, done=0, illegal_op=0, iteration counter=0. Applies immediately, including mid-MUL/DIV; the partial result is discarded.
- Acceptance: a rising clk edge with state=IDLE and alu_en=1. alu_en in any other state is ignored. alu_en held high across consecutive IDLE edges re-issues the command each edge.
- At acceptance:
  - rs1_data, op2 (muxed per op2_dir), alu_op and the immediates are latched.
  - rs1/op2 changing after acceptance has no effect.
- Single-cycle ops (0-2, 5-11, illegal): result/zero/done are registered at the acceptance edge; busy stays 0; state stays IDLE.
  - ADD/ADDI: op1+op2, modulo 2^32. ADDI uses op2 as supplied by op2_dir (the controller drives 10).
  - SUB: op1-op2, modulo 2^32.
  - SLL/SRL: shift by op2[4:0]; SRL is logical.
  - AND/OR/XOR: bitwise.
  - NOT: ~op1.
  - LUI: {U-imm, 12'b0}.
  - Illegal op: result=0, zero=1, illegal_op=1.
- FSM states: IDLE, MUL_RUN, DIV_RUN, DIV_FIX.
- MUL, IDLE->MUL_RUN:
  - Shift-add, unsigned, BITS_PER_CYCLE bits per edge.
  - Low 32 bits of the product are kept; sign-agnostic because only the low half is kept.
  - On the Nth MUL_RUN edge: result, zero and done are registered, busy drops, and the FSM returns to IDLE.
  - Latency: done is visible N cycles after the single-cycle case (N=32 by default).
- DIV, signed, quotient truncated toward zero:
  - Divide by zero (op2==0): result=32'hFFFFFFFF, single-cycle, no busy.
  - Overflow (op1=32'h80000000, op2=32'hFFFFFFFF): result=32'h80000000, single-cycle.
  - Otherwise IDLE->DIV_RUN:
    - Record the operand signs and absolute values.
    - Run an unsigned restoring divide for N edges.
    - Then DIV_FIX for one edge, negating the quotient if the signs differ.
    - result, zero and done are registered in DIV_FIX; DIV_FIX->IDLE.
  - Latency: N+1 cycles beyond the single-cycle case.
- busy = (state != IDLE). done and busy are never both high on the cycle done is visible.
- Wrap-around: the iteration counter is log2(N)+1 bits and is cleared on acceptance. No wrap in the arithmetic beyond the modulo-2^32 rules above.

Test Plan:
- ADD: rs1=5, rs2=7, op2_dir=00, alu_en one cycle -> result=12, zero=0, done high 1 cycle after acceptance, busy never high.
- ADDI/LUI:
  - rs1=10, instr[31:20]=12'hFFF, op2_dir=10 -> result=9.
  - LUI with instr[31:12]=20'h12345 -> result=32'h12345000.
- MUL: rs1=32'hFFFFFFFF, rs2=3 -> busy high 32 cycles, then result=32'hFFFFFFFD with a single done pulse.
  - alu_en pulsed mid-run is ignored.
  - Repeat with BITS_PER_CYCLE=4 -> busy 8 cycles.
- DIV:
  - -7/2 -> 32'hFFFFFFFD after 33 busy cycles.
  - 7/-2 -> 32'hFFFFFFFD.
  - 6/3 -> 2.
  - 1/2 -> 0 with zero=1.
- DIV corners:
  - 5/0 -> 32'hFFFFFFFF, single-cycle, busy=0.
  - 32'h80000000/-1 -> 32'h80000000, single-cycle.
- Reset/illegal:
  - rst_n low 10 cycles into a DIV -> busy, done, result=0 immediately (async).
  - A fresh ADD afterwards completes correctly.
  - alu_op=8'd200 -> result=0, illegal_op and done pulse together.
